// File: rtl/controle_relogio.sv
// Digital clock controller: HH:MM:SS counting driven by a 1 Hz strobe, plus a
// three-mode button interface for setting hours and minutes with a blink flag.
module controle_relogio #(
  parameter int unsigned HOURS_MOD = 24
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StSetHour = 2'd1;
  localparam logic [1:0] StSetMin  = 2'd2;

  localparam logic [4:0] HourMax = 5'(HOURS_MOD - 1);
  localparam logic [5:0] SixtyMax = 6'd59;

  logic clk_d;
  logic mode_s1_q, mode_s2_q, mode_hist_q;
  logic inc_s1_q, inc_s2_q, inc_hist_q;
  logic tick, mode_pulse, inc_pulse;

  logic [4:0] hours_q, hours_d, run_hours;
  logic [5:0] minutes_q, minutes_d, run_minutes;
  logic [5:0] seconds_q, seconds_d, run_seconds;
  logic [1:0] mode_q, mode_d;
  logic       blink_q, blink_d;

  // Edge detectors; flops reset high so inputs already high at release stay silent.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      clk_d       <= 1'b1;
      mode_s1_q   <= 1'b1;
      mode_s2_q   <= 1'b1;
      mode_hist_q <= 1'b1;
      inc_s1_q    <= 1'b1;
      inc_s2_q    <= 1'b1;
      inc_hist_q  <= 1'b1;
    end else begin
      clk_d       <= clk_1hz;
      mode_s1_q   <= btn_mode;
      mode_s2_q   <= mode_s1_q;
      mode_hist_q <= mode_s2_q;
      inc_s1_q    <= btn_inc;
      inc_s2_q    <= inc_s1_q;
      inc_hist_q  <= inc_s2_q;
    end
  end

  assign tick       = clk_1hz & ~clk_d;
  assign mode_pulse = mode_s2_q & ~mode_hist_q;
  assign inc_pulse  = inc_s2_q & ~inc_hist_q;

  // Time advanced by one second, with cascaded compare-at-maximum wraps.
  always_comb begin
    run_seconds = (seconds_q == SixtyMax) ? 6'd0 : seconds_q + 6'd1;
    run_minutes = minutes_q;
    run_hours   = hours_q;
    if (seconds_q == SixtyMax) begin
      run_minutes = (minutes_q == SixtyMax) ? 6'd0 : minutes_q + 6'd1;
      if (minutes_q == SixtyMax) begin
        run_hours = (hours_q == HourMax) ? 5'd0 : hours_q + 5'd1;
      end
    end
  end

  always_comb begin
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    mode_d    = mode_q;
    blink_d   = blink_q;
    if (mode_pulse) begin
      // Mode change dominates: any inc is dropped and blink restarts visible.
      blink_d = 1'b1;
      case (mode_q)
        StRun: begin
          mode_d = StSetHour;
          if (tick) begin
            hours_d   = run_hours;
            minutes_d = run_minutes;
            seconds_d = run_seconds;
          end
        end
        StSetHour: mode_d = StSetMin;
        StSetMin: begin
          mode_d    = StRun;
          seconds_d = 6'd0;
        end
        default: mode_d = StRun;
      endcase
    end else begin
      case (mode_q)
        StRun: begin
          if (tick) begin
            hours_d   = run_hours;
            minutes_d = run_minutes;
            seconds_d = run_seconds;
          end
        end
        StSetHour: begin
          if (tick) blink_d = ~blink_q;
          if (inc_pulse) hours_d = (hours_q == HourMax) ? 5'd0 : hours_q + 5'd1;
        end
        StSetMin: begin
          if (tick) blink_d = ~blink_q;
          if (inc_pulse) minutes_d = (minutes_q == SixtyMax) ? 6'd0 : minutes_q + 6'd1;
        end
        default: mode_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      hours_q   <= 5'd0;
      minutes_q <= 6'd0;
      seconds_q <= 6'd0;
      mode_q    <= StRun;
      blink_q   <= 1'b1;
    end else begin
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      mode_q    <= mode_d;
      blink_q   <= blink_d;
    end
  end

  assign hours   = hours_q;
  assign minutes = minutes_q;
  assign seconds = seconds_q;
  assign mode    = mode_q;
  assign blink   = blink_q;

endmodule

// File: doc/controle_relogio.md
CONTROLE_RELOGIO -- requirements
Module: controle_relogio

Interface
REQ-001 Parameter HOURS_MOD, default 24, hour wrap modulus; legal values are 12 or 24, and hours range over 0..HOURS_MOD-1.
REQ-002 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 clk_1hz  input  1  1 Hz square wave from the clock divider, same clk_in domain; each rising edge marks one second.
REQ-005 btn_mode  input  1  debounced button level, asynchronous, active-high; each rising edge advances the mode.
REQ-006 btn_inc  input  1  debounced button level, asynchronous, active-high; each rising edge increments the selected field.
REQ-007 hours  output  5  current hours, 0..HOURS_MOD-1.
REQ-008 minutes  output  6  current minutes, 0..59.
REQ-009 seconds  output  6  current seconds, 0..59.
REQ-010 mode  output  2  encoding: 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN; the value 3 is never driven.
REQ-011 blink  output  1  display-visible flag for the selected field; constant 1 in RUN.

Function
REQ-012 Second tick: register clk_1hz into clk_d; tick = clk_1hz AND NOT clk_d; the tick is exactly one clk_in cycle wide per clk_1hz rising edge.
REQ-013 The effect of a tick appears on the outputs 1 cycle after the first cycle in which clk_1hz is sampled high.
REQ-014 Each button passes through a 2-flop synchronizer followed by one history flop; pulse = sync2 AND NOT hist.
REQ-015 Button effect latency: the output reflects the change 3 clk_in cycles after the button input rises.
REQ-016 A button held high produces exactly one pulse, with no auto-repeat.
REQ-017 Mode FSM transitions: RUN -> SET_HOUR -> SET_MIN -> RUN, advancing one step per mode pulse.
REQ-018 RUN: each tick increments seconds.
REQ-019 RUN: when seconds wraps 59 -> 0, minutes increments in the same cycle.
REQ-020 RUN: when minutes wraps 59 -> 0 (on a seconds carry), hours increments in the same cycle.
REQ-021 RUN: hours wraps HOURS_MOD-1 -> 0; 23:59:59 plus a tick gives 00:00:00 when HOURS_MOD = 24.
REQ-022 RUN: inc pulses are ignored.
REQ-023 SET_HOUR / SET_MIN: ticks do not change hours, minutes or seconds.
REQ-024 SET_HOUR / SET_MIN: each tick toggles blink.
REQ-025 SET_HOUR: an inc pulse sets hours to (hours+1) mod HOURS_MOD; minutes and seconds are unchanged.
REQ-026 SET_MIN: an inc pulse sets minutes to (minutes+1) mod 60 with no carry into hours; seconds are unchanged.
REQ-027 The SET_MIN -> RUN transition clears seconds to 0 in the same cycle that mode becomes RUN.
REQ-028 Every mode transition forces blink to 1.
REQ-029 Simultaneous mode and inc pulses: the mode pulse wins; the inc is discarded and no field changes.
REQ-030 Simultaneous tick and mode pulse in RUN: the time increments and the mode advances in the same cycle.
REQ-031 Simultaneous tick and mode pulse in a set mode: the mode advances and blink = 1; the tick toggle is discarded.
REQ-032 Simultaneous tick and inc pulse in a set mode: the field increments and blink toggles.
REQ-033 Counter arithmetic uses compare-at-maximum wrap; counters never hold out-of-range values.

Reset
REQ-034 While rst = 0 at a clk_in edge: hours = 0, minutes = 0, seconds = 0, mode = RUN, blink = 1.
REQ-035 While rst = 0 at a clk_in edge: clk_d, all synchronizer flops and all history flops load 1.
REQ-036 After reset release, an input already high (clk_1hz or either button) generates no tick or pulse until it falls and rises again.
REQ-037 Reset asserted mid-operation takes effect at the next clk_in edge, regardless of mode or pending pulses.

Verification
REQ-038 Reset, then 3 clk_1hz rising edges -> 00:00:03, mode = 0, blink = 1 throughout.
REQ-039 Mode pulses x3 -> mode 1, 2, 0; 5 inc pulses while in RUN -> time unchanged.
REQ-040 SET_HOUR with 25 inc pulses from 0 -> hours = 1; 4 ticks in SET_HOUR -> seconds unchanged and blink sequence 0, 1, 0, 1.
REQ-041 Set 23:59, return to RUN (seconds = 0), then 59 ticks -> 23:59:59, 1 more tick -> 00:00:00; with HOURS_MOD = 12, 11:59:59 plus a tick -> 00:00:00.
REQ-042 Mode and inc rising in the same cycle while in SET_MIN at minutes = 10 -> mode = RUN, minutes = 10, seconds = 0.
REQ-043 At 12:34:56 in SET_MIN, assert rst for 1 cycle with clk_1hz and btn_inc held high across release -> 00:00:00, RUN, blink = 1, and no increment until each input re-rises.
